// File: rtl/ctech_lib_cdc_bus_tx.sv
// rtl/ctech_lib_cdc_bus_tx.sv - source-domain transmit end of a req/ack bus crossing
// Launches a word from flops on tx_req and holds it until the synchronized ack returns.
module ctech_lib_cdc_bus_tx #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FOUR_PHASE  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             tx_req,
    output logic [WIDTH-1:0] tx_data,
    input  logic             tx_ack_async,
    output logic             busy,
    output logic             err
);

    generate
        if (SYNC_STAGES < 2) begin : g_sync_stages_check
            $error("ctech_lib_cdc_bus_tx: SYNC_STAGES must be >= 2");
        end
    endgenerate

    localparam bit FOUR_PH = (FOUR_PHASE != 0);

    // Two-phase mode reuses ST_WAIT_HI as its single wait state.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_WAIT_LO = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   req_q, req_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic                   err_q, err_d;
    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic                   ack_s;
    logic                   idle_ack_exp;

    assign ack_s        = ack_sync_q[SYNC_STAGES-1];
    assign idle_ack_exp = FOUR_PH ? 1'b0 : req_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            data_q     <= '0;
            err_q      <= 1'b0;
            ack_sync_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            data_q     <= data_d;
            err_q      <= err_d;
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], tx_ack_async};
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                // An ack moving while nothing is outstanding is a protocol fault; flag it but keep running.
                if (ack_s != idle_ack_exp) begin
                    err_d = 1'b1;
                end
                if (in_valid) begin
                    data_d  = in_data;
                    req_d   = FOUR_PH ? 1'b1 : ~req_q;
                    state_d = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (FOUR_PH) begin
                    if (ack_s) begin
                        req_d   = 1'b0;
                        state_d = ST_WAIT_LO;
                    end
                end else if (ack_s == req_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_LO: begin
                if (!ack_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign tx_req   = req_q;
    assign tx_data  = data_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ctech_lib_cdc_bus_tx.sv
// tb/tb_ctech_lib_cdc_bus_tx.sv - self-checking bench for two- and four-phase bus transmitters
module tb_ctech_lib_cdc_bus_tx;

    localparam int W = 8;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         loop_en;
    logic         in_valid [2];
    logic [W-1:0] in_data  [2];
    logic         in_ready [2];
    logic         tx_req   [2];
    logic [W-1:0] tx_data  [2];
    logic         busy     [2];
    logic         err      [2];
    logic         ack_man  [2];
    logic         tx_ack   [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign tx_ack[0] = loop_en ? tx_req[0] : ack_man[0];
    assign tx_ack[1] = loop_en ? tx_req[1] : ack_man[1];

    ctech_lib_cdc_bus_tx #(.WIDTH(W), .SYNC_STAGES(S), .FOUR_PHASE(0)) u_dut_2ph (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_data(in_data[0]),
        .in_ready(in_ready[0]), .tx_req(tx_req[0]), .tx_data(tx_data[0]),
        .tx_ack_async(tx_ack[0]), .busy(busy[0]), .err(err[0])
    );

    ctech_lib_cdc_bus_tx #(.WIDTH(W), .SYNC_STAGES(S), .FOUR_PHASE(1)) u_dut_4ph (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_data(in_data[1]),
        .in_ready(in_ready[1]), .tx_req(tx_req[1]), .tx_data(tx_data[1]),
        .tx_ack_async(tx_ack[1]), .busy(busy[1]), .err(err[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Destination-side observer: records each launched word and checks the launch rules.
    logic         mon_en, err_chk, mlaunch;
    logic         pre_valid [2], pre_ready [2], pre_busy [2], pre_req [2];
    logic [W-1:0] pre_din   [2], pre_dout  [2];
    logic [W-1:0] rx_mem    [2][64];
    int           rx_n      [2] = '{0, 0};
    logic [W-1:0] exp_mem   [2][64];
    int           exp_n     [2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            pre_valid[k] = in_valid[k];
            pre_ready[k] = in_ready[k];
            pre_busy[k]  = busy[k];
            pre_req[k]   = tx_req[k];
            pre_din[k]   = in_data[k];
            pre_dout[k]  = tx_data[k];
        end
    end

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                mlaunch = (k == 0) ? (tx_req[k] !== pre_req[k]) : (tx_req[k] && !pre_req[k]);
                check($sformatf("mon%0d_accept", k), 32'(mlaunch), 32'(pre_valid[k] && pre_ready[k]));
                check($sformatf("mon%0d_ready_busy", k), 32'(in_ready[k]), 32'(!busy[k]));
                if (pre_busy[k] && busy[k])
                    check($sformatf("mon%0d_hold", k), 32'(tx_data[k]), 32'(pre_dout[k]));
                if (mlaunch) begin
                    check($sformatf("mon%0d_word", k), 32'(tx_data[k]), 32'(pre_din[k]));
                    if (rx_n[k] < 64) begin
                        rx_mem[k][rx_n[k]] = tx_data[k];
                        rx_n[k]++;
                    end
                end
                if (err_chk) check($sformatf("mon%0d_err", k), 32'(err[k]), 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int k, input string name);
        int cnt = 0;
        while (busy[k] && cnt < 200) begin
            step();
            cnt++;
        end
        check(name, 32'(busy[k]), 32'd0);
    endtask

    task automatic drive_words(input int k, input int n, input int max_gap, input bit chk_period);
        int           last_acc = 0;
        int           cnt;
        logic         r;
        logic [W-1:0] w;
        for (int i = 0; i < n; i++) begin
            w           = 8'($urandom);
            in_valid[k] = 1'b1;
            in_data[k]  = w;
            cnt         = 0;
            do begin
                @(negedge clk);
                r = in_ready[k];
                step();
                cnt++;
            end while (!r && cnt < 200);
            check($sformatf("drv%0d_accept_timeout", k), 32'(r), 32'd1);
            if (r && exp_n[k] < 64) begin
                exp_mem[k][exp_n[k]] = w;
                exp_n[k]++;
            end
            if (chk_period && i > 0) check("b2b_period", 32'(cyc - last_acc), 32'(S + 2));
            last_acc    = cyc;
            in_valid[k] = 1'b0;
            in_data[k]  = 8'($urandom);
            repeat ($urandom_range(0, max_gap)) step();
        end
    endtask

    task automatic dest(input int k, input int n);
        int cnt;
        for (int i = 0; i < n; i++) begin
            cnt = 0;
            if (k == 0) begin
                while (tx_req[k] === ack_man[k] && cnt < 400) begin @(posedge clk); #2; cnt++; end
                check("dest0_req_timeout", 32'(cnt < 400), 32'd1);
                repeat ($urandom_range(0, 20)) @(posedge clk);
                #($urandom_range(0, 9));
                ack_man[k] = tx_req[k];
            end else begin
                while (tx_req[k] !== 1'b1 && cnt < 400) begin @(posedge clk); #2; cnt++; end
                check("dest1_req_hi_timeout", 32'(cnt < 400), 32'd1);
                repeat ($urandom_range(0, 20)) @(posedge clk);
                #($urandom_range(0, 9));
                ack_man[k] = 1'b1;
                cnt = 0;
                while (tx_req[k] !== 1'b0 && cnt < 400) begin @(posedge clk); #2; cnt++; end
                check("dest1_req_lo_timeout", 32'(cnt < 400), 32'd1);
                repeat ($urandom_range(0, 20)) @(posedge clk);
                #($urandom_range(0, 9));
                ack_man[k] = 1'b0;
            end
        end
    endtask

    task automatic compare_stream(input int k, input int base, input int n, input string name);
        check($sformatf("%s_count", name), 32'(rx_n[k] - base), 32'(n));
        for (int i = 0; i < n && base + i < 64; i++)
            check($sformatf("%s_word%0d", name, i), 32'(rx_mem[k][base + i]), 32'(exp_mem[k][i]));
    endtask

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         rdy;
        logic         req;
        logic [W-1:0] data;
        logic         bsy;
    } vec_t;

    vec_t tab [2][9];

    initial begin
        int base0, base1;

        tab[0][0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b1};
        tab[0][1] = '{1'b1, 8'h11, 1'b0, 1'b1, 8'hA5, 1'b1};
        tab[0][2] = '{1'b1, 8'h22, 1'b0, 1'b1, 8'hA5, 1'b1};
        tab[0][3] = '{1'b1, 8'h33, 1'b1, 1'b1, 8'hA5, 1'b0};
        tab[0][4] = '{1'b1, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1};
        tab[0][5] = '{1'b0, 8'h44, 1'b0, 1'b0, 8'h3C, 1'b1};
        tab[0][6] = '{1'b0, 8'h55, 1'b0, 1'b0, 8'h3C, 1'b1};
        tab[0][7] = '{1'b0, 8'h66, 1'b1, 1'b0, 8'h3C, 1'b0};
        tab[0][8] = '{1'b0, 8'h77, 1'b1, 1'b0, 8'h3C, 1'b0};
        tab[1][0] = '{1'b1, 8'h5A, 1'b0, 1'b1, 8'h5A, 1'b1};
        tab[1][1] = '{1'b1, 8'h77, 1'b0, 1'b1, 8'h5A, 1'b1};
        tab[1][2] = '{1'b0, 8'h88, 1'b0, 1'b1, 8'h5A, 1'b1};
        tab[1][3] = '{1'b0, 8'h99, 1'b0, 1'b0, 8'h5A, 1'b1};
        tab[1][4] = '{1'b1, 8'hAA, 1'b0, 1'b0, 8'h5A, 1'b1};
        tab[1][5] = '{1'b1, 8'hBB, 1'b0, 1'b0, 8'h5A, 1'b1};
        tab[1][6] = '{1'b1, 8'hCC, 1'b1, 1'b0, 8'h5A, 1'b0};
        tab[1][7] = '{1'b1, 8'hC3, 1'b0, 1'b1, 8'hC3, 1'b1};
        tab[1][8] = '{1'b0, 8'hDD, 1'b0, 1'b1, 8'hC3, 1'b1};

        rst      = 1'b0;
        loop_en  = 1'b1;
        mon_en   = 1'b0;
        err_chk  = 1'b0;
        exp_n    = '{0, 0};
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0;
            in_data[k]  = '0;
            ack_man[k]  = 1'b0;
        end
        #1 rst = 1'b1;
        #2;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst%0d_req", k),   32'(tx_req[k]),   32'd0);
            check($sformatf("rst%0d_data", k),  32'(tx_data[k]),  32'd0);
            check($sformatf("rst%0d_err", k),   32'(err[k]),      32'd0);
            check($sformatf("rst%0d_busy", k),  32'(busy[k]),     32'd0);
            check($sformatf("rst%0d_ready", k), 32'(in_ready[k]), 32'd1);
        end
        @(posedge clk);
        #3 rst = 1'b0;
        step();

        // Loopback edge-by-edge tables, including a held in_valid on the ack-complete edge.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 9; i++) begin
                in_valid[k] = tab[k][i].v;
                in_data[k]  = tab[k][i].d;
                step();
                check($sformatf("tbl%0d_e%0d_ready", k, i), 32'(in_ready[k]), 32'(tab[k][i].rdy));
                check($sformatf("tbl%0d_e%0d_req", k, i),   32'(tx_req[k]),   32'(tab[k][i].req));
                check($sformatf("tbl%0d_e%0d_data", k, i),  32'(tx_data[k]),  32'(tab[k][i].data));
                check($sformatf("tbl%0d_e%0d_busy", k, i),  32'(busy[k]),     32'(tab[k][i].bsy));
            end
            in_valid[k] = 1'b0;
        end
        wait_idle(1, "tbl1_drain");
        check("tbl_err0", 32'(err[0]), 32'd0);
        check("tbl_err1", 32'(err[1]), 32'd0);

        // Sixteen back-to-back words through the two-phase loopback.
        mon_en   = 1'b1;
        base0    = rx_n[0];
        exp_n[0] = 0;
        drive_words(0, 16, 0, 1'b1);
        wait_idle(0, "b2b_drain");
        step();
        compare_stream(0, base0, 16, "b2b");

        // Randomized ack delay and phase on both flavours with an independent destination.
        ack_man[0] = tx_req[0];
        ack_man[1] = 1'b0;
        #1 loop_en = 1'b0;
        err_chk    = 1'b1;
        base0      = rx_n[0];
        base1      = rx_n[1];
        exp_n      = '{0, 0};
        fork
            drive_words(0, 30, 3, 1'b0);
            dest(0, 30);
            drive_words(1, 30, 3, 1'b0);
            dest(1, 30);
        join
        step();
        wait_idle(0, "rnd0_drain");
        wait_idle(1, "rnd1_drain");
        step();
        compare_stream(0, base0, 30, "rnd0");
        compare_stream(1, base1, 30, "rnd1");
        mon_en  = 1'b0;
        err_chk = 1'b0;

        // Spurious ack toggle while idle on the two-phase instance.
        @(posedge clk);
        #3 ack_man[0] = ~ack_man[0];
        step();
        step();
        check("spur_err_before", 32'(err[0]), 32'd0);
        step();
        check("spur_err_set", 32'(err[0]), 32'd1);
        ack_man[0] = ~ack_man[0];
        repeat (10) step();
        check("spur_err_sticky", 32'(err[0]), 32'd1);
        check("spur_busy", 32'(busy[0]), 32'd0);

        // Asynchronous reset in the middle of a transfer with tx_req high.
        if (tx_req[0]) begin
            in_valid[0] = 1'b1;
            in_data[0]  = 8'h42;
            step();
            in_valid[0] = 1'b0;
            ack_man[0]  = tx_req[0];
            wait_idle(0, "pre_rst_drain");
        end
        in_valid[0] = 1'b1;
        in_data[0]  = 8'hE7;
        step();
        in_valid[0] = 1'b0;
        check("pre_rst_req", 32'(tx_req[0]), 32'd1);
        check("pre_rst_busy", 32'(busy[0]), 32'd1);
        step();
        step();
        #3 rst = 1'b1;
        #1;
        check("midrst_req",   32'(tx_req[0]),   32'd0);
        check("midrst_data",  32'(tx_data[0]),  32'd0);
        check("midrst_busy",  32'(busy[0]),     32'd0);
        check("midrst_ready", 32'(in_ready[0]), 32'd1);
        check("midrst_err",   32'(err[0]),      32'd0);
        ack_man[0] = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        repeat (5) step();
        check("post_rst_err",  32'(err[0]),  32'd0);
        check("post_rst_busy", 32'(busy[0]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
